fazyrv_spm_d_seq: RTL and testbench
===================================

Name: fazyrv_spm_d_seq

Overview:
Sequencer for the data scratchpad (spm_d) of the FazyRV core. It steps spm_d through its phases for loads, stores and shifts:
- serial operand/address shift-in;
- dmem wait with bus strobe/ack handshake;
- shift-in-place;
- serial read-out.

It generates the chunk counter (icyc) and the LSB/MSB flags, and returns a one-cycle done or trap to the core control.

Parameters:
BWIDTH, 1, datapath chunk width in bits (1, 2, 4 or 8).
NO_ICYC, 32/BWIDTH, chunks per 32-bit word.

Ports:
clk_i  in  1  clock, rising edge
rst_in  in  1  asynchronous reset, active low
start_i  in  1  issue request, sampled only in IDLE
instr_ld_i  in  1  issued op is a load
instr_st_i  in  1  issued op is a store
shft_op_i  in  1  issued op is a shift
misalngd_i  in  1  misaligned access flag from spm_d
shft_done_i  in  1  spm_d shift-complete flag
dmem_ack_i  in  1  data memory acknowledge
dmem_stb_o  out  1  data memory strobe
dmem_we_o  out  1  data memory write enable
ld_par_o  out  1  parallel load of dmem read data into spm_d
icyc_o  out  $clog2(NO_ICYC)  current chunk index
icyc_lsb_o  out  1  chunk holds bit 0
icyc_msb_o  out  1  chunk holds bit 31
cyc_rd_o  out  1  read-out phase
cyc_wt_o  out  1  dmem wait phase
cyc_shft_o  out  1  shift phase
busy_o  out  1  operation in progress
done_o  out  1  one-cycle completion pulse
trap_o  out  1  one-cycle misaligned-trap pulse

Behaviour:
- Clock is clk_i. Reset rst_in is asynchronous and active low.
- During reset: state IDLE, icyc 0, latched op 0, all outputs 0. Reset mid-operation aborts the op immediately. No done_o or trap_o is produced for the aborted op.
- States: IDLE, ADR, WAIT, SHFT, RD, DONE, TRAP. State decode drives cyc_wt_o (WAIT), cyc_shft_o (SHFT) and cyc_rd_o (RD). busy_o is high in every state except IDLE.
- Op latch:
  - Op is captured at the start_i edge in IDLE, with priority ld > st > shft.
  - start_i with no op bit set is ignored.
  - start_i outside IDLE is ignored.
- IDLE -> ADR on an accepted start.
- ADR:
  - Lasts exactly NO_ICYC cycles, icyc counting 0..NO_ICYC-1.
  - At the last chunk, the next state is:
    - shift: SHFT;
    - load/store with misalngd_i=1: TRAP;
    - otherwise: WAIT.
  - misalngd_i is sampled only in the last ADR cycle.
- WAIT:
  - dmem_stb_o=1. dmem_we_o equals the store bit (combinational from state and latched op).
  - Holds until dmem_ack_i; there is no timeout.
  - On ack, store goes to DONE.
  - On ack, load asserts ld_par_o in the same cycle (combinational: WAIT & ack & load), then goes to RD.
  - ld_par_o is high only in that cycle.
- SHFT:
  - Go to RD in the cycle shft_done_i=1.
  - A minimum of one SHFT cycle is always spent.
- RD: exactly NO_ICYC cycles, icyc 0..NO_ICYC-1, then DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- TRAP: trap_o=1 for one cycle, then IDLE. dmem_stb_o is never asserted for a trapped op.
- icyc counter:
  - Increments in ADR and RD, with natural wrap at NO_ICYC-1 (power of two).
  - Cleared to 0 on every phase entry and in all other states.
  - icyc_lsb_o = (icyc==0) & (ADR|RD).
  - icyc_msb_o = (icyc==NO_ICYC-1) & (ADR|RD).
  - When NO_ICYC=1, icyc_o is width 1 and held 0, and both flags are high in each ADR/RD cycle.
- dmem_ack_i outside WAIT is ignored.
- Back-to-back operation: start_i asserted in the cycle after DONE (in IDLE) is accepted. The minimum idle gap is 1 cycle.

Test Plan:
1. BWIDTH=1, load, start_i at cycle 0, ack at cycle 35 -> ADR cycles 1–32, dmem_stb_o cycles 33–35, ld_par_o only at cycle 35, cyc_rd_o cycles 36–67, done_o at cycle 68, busy_o low at cycle 69.
2. BWIDTH=1, store, ack at cycle 33 -> dmem_we_o=1 at cycle 33, done_o at cycle 34, no cyc_rd_o and no ld_par_o.
3. BWIDTH=1, shift, shft_done_i high at cycle 36 -> cyc_shft_o cycles 33–36, cyc_rd_o cycles 37–68, done_o at cycle 69, dmem_stb_o never set.
4. BWIDTH=1, load with misalngd_i=1 at cycle 32 -> trap_o at cycle 33, no strobe, no done_o, IDLE at cycle 34.
5. BWIDTH=8 load -> icyc_o sequence 0,1,2,3 with lsb at 0 and msb at 3 in both ADR and RD.
6. Reset:
   - rst_in low asynchronously during WAIT -> all outputs 0 immediately; a later ack is ignored.
   - start_i asserted during busy -> ignored.

Source files
------------

// File: rtl/fazyrv_spm_d_seq.sv
// Phase sequencer for the FazyRV data scratchpad: address shift-in, dmem handshake,
// in-place shift and serial read-out, with chunk counter and one-cycle done/trap pulses.
module fazyrv_spm_d_seq #(
  parameter int unsigned BWIDTH  = 1,
  parameter int unsigned NO_ICYC = 32 / BWIDTH,
  localparam int unsigned IcycW  = (NO_ICYC > 1) ? $clog2(NO_ICYC) : 1
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             start_i,
  input  logic             instr_ld_i,
  input  logic             instr_st_i,
  input  logic             shft_op_i,
  input  logic             misalngd_i,
  input  logic             shft_done_i,
  input  logic             dmem_ack_i,
  output logic             dmem_stb_o,
  output logic             dmem_we_o,
  output logic             ld_par_o,
  output logic [IcycW-1:0] icyc_o,
  output logic             icyc_lsb_o,
  output logic             icyc_msb_o,
  output logic             cyc_rd_o,
  output logic             cyc_wt_o,
  output logic             cyc_shft_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             trap_o
);

  localparam logic [IcycW-1:0] IcycLast = IcycW'(NO_ICYC - 1);

  typedef enum logic [2:0] {
    StIdle, StAdr, StWait, StShft, StRd, StDone, StTrap
  } state_e;

  typedef enum logic [1:0] {
    OpNone, OpLd, OpSt, OpShft
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [IcycW-1:0] icyc_q, icyc_d;
  logic             icyc_last;
  logic             chunk_phase;

  assign icyc_last   = (icyc_q == IcycLast);
  assign chunk_phase = (state_q == StAdr) || (state_q == StRd);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && (instr_ld_i || instr_st_i || shft_op_i)) begin
          state_d = StAdr;
          if (instr_ld_i)      op_d = OpLd;
          else if (instr_st_i) op_d = OpSt;
          else                 op_d = OpShft;
        end
      end
      StAdr: begin
        // misalignment is only meaningful once the full address has been shifted in
        if (icyc_last) begin
          if (op_q == OpShft)  state_d = StShft;
          else if (misalngd_i) state_d = StTrap;
          else                 state_d = StWait;
        end
      end
      StWait: begin
        if (dmem_ack_i) state_d = (op_q == OpLd) ? StRd : StDone;
      end
      StShft: begin
        if (shft_done_i) state_d = StRd;
      end
      StRd: begin
        if (icyc_last) state_d = StDone;
      end
      StDone, StTrap: state_d = StIdle;
      default:        state_d = StIdle;
    endcase

    // counter runs only while staying inside a chunked phase; any entry restarts at 0
    icyc_d = '0;
    if (chunk_phase && (state_d == state_q)) icyc_d = icyc_q + IcycW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= StIdle;
      op_q    <= OpNone;
      icyc_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      icyc_q  <= icyc_d;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign cyc_wt_o   = (state_q == StWait);
  assign cyc_shft_o = (state_q == StShft);
  assign cyc_rd_o   = (state_q == StRd);
  assign done_o     = (state_q == StDone);
  assign trap_o     = (state_q == StTrap);
  assign dmem_stb_o = cyc_wt_o;
  assign dmem_we_o  = cyc_wt_o && (op_q == OpSt);
  assign ld_par_o   = cyc_wt_o && dmem_ack_i && (op_q == OpLd);
  assign icyc_o     = icyc_q;
  assign icyc_lsb_o = chunk_phase && (icyc_q == '0);
  assign icyc_msb_o = chunk_phase && icyc_last;

endmodule

// File: tb/tb_fazyrv_spm_d_seq.sv
// Scoreboard bench for fazyrv_spm_d_seq: random ops, per-op expected summary checked on done/trap.
module tb_fazyrv_spm_d_seq;

  localparam int N = 32;

  logic clk_i = 1'b0;
  logic rst_in;
  logic start_i, instr_ld_i, instr_st_i, shft_op_i, misalngd_i, shft_done_i, dmem_ack_i;
  logic dmem_stb_o, dmem_we_o, ld_par_o, icyc_lsb_o, icyc_msb_o;
  logic cyc_rd_o, cyc_wt_o, cyc_shft_o, busy_o, done_o, trap_o;
  logic [4:0] icyc_o;

  // second instance, BWIDTH=8, used for the short directed chunk-counter test
  logic s8_start, s8_ld, s8_ack;
  logic s8_stb, s8_we, s8_ldpar, s8_lsb, s8_msb, s8_rd, s8_wt, s8_shft, s8_busy, s8_done, s8_trap;
  logic [1:0] s8_icyc;

  always #5 clk_i = ~clk_i;

  fazyrv_spm_d_seq #(.BWIDTH(1)) u_dut (
    .clk_i(clk_i), .rst_in(rst_in), .start_i(start_i), .instr_ld_i(instr_ld_i),
    .instr_st_i(instr_st_i), .shft_op_i(shft_op_i), .misalngd_i(misalngd_i),
    .shft_done_i(shft_done_i), .dmem_ack_i(dmem_ack_i), .dmem_stb_o(dmem_stb_o),
    .dmem_we_o(dmem_we_o), .ld_par_o(ld_par_o), .icyc_o(icyc_o), .icyc_lsb_o(icyc_lsb_o),
    .icyc_msb_o(icyc_msb_o), .cyc_rd_o(cyc_rd_o), .cyc_wt_o(cyc_wt_o),
    .cyc_shft_o(cyc_shft_o), .busy_o(busy_o), .done_o(done_o), .trap_o(trap_o)
  );

  fazyrv_spm_d_seq #(.BWIDTH(8)) u_dut8 (
    .clk_i(clk_i), .rst_in(rst_in), .start_i(s8_start), .instr_ld_i(s8_ld),
    .instr_st_i(1'b0), .shft_op_i(1'b0), .misalngd_i(1'b0), .shft_done_i(1'b0),
    .dmem_ack_i(s8_ack), .dmem_stb_o(s8_stb), .dmem_we_o(s8_we), .ld_par_o(s8_ldpar),
    .icyc_o(s8_icyc), .icyc_lsb_o(s8_lsb), .icyc_msb_o(s8_msb), .cyc_rd_o(s8_rd),
    .cyc_wt_o(s8_wt), .cyc_shft_o(s8_shft), .busy_o(s8_busy), .done_o(s8_done),
    .trap_o(s8_trap)
  );

  typedef struct {
    int kind;  // 1 = done, 2 = trap
    int lat;   // busy cycles up to and including the done/trap cycle
    int stb;
    int we;
    int lp;
    int rd;
    int sh;
    int lsb;
    int msb;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- monitor ----------------
  int m_bcnt, m_stb, m_we, m_lp, m_rd, m_sh, m_lsb, m_msb, m_icerr;

  task automatic mon_clear();
    m_bcnt = 0; m_stb = 0; m_we = 0; m_lp = 0; m_rd = 0; m_sh = 0;
    m_lsb = 0; m_msb = 0; m_icerr = 0;
  endtask

  initial mon_clear();

  always @(negedge clk_i) begin : mon
    exp_t e;
    int   exp_ic;
    if (!rst_in) begin
      mon_clear();
    end else if (!busy_o) begin
      chk("idle_quiet", int'({dmem_stb_o, dmem_we_o, ld_par_o, cyc_rd_o, cyc_wt_o, cyc_shft_o,
                              done_o, trap_o, icyc_lsb_o, icyc_msb_o, icyc_o}), 0);
    end else begin
      m_bcnt++;
      if (dmem_stb_o) m_stb++;
      if (dmem_we_o)  m_we++;
      if (cyc_shft_o) m_sh++;
      if (icyc_lsb_o) m_lsb++;
      if (icyc_msb_o) m_msb++;
      if (ld_par_o) begin
        m_lp++;
        chk("ldpar_with_ack", int'({dmem_ack_i, cyc_wt_o}), 3);
      end
      if (m_bcnt <= N)   exp_ic = m_bcnt - 1;
      else if (cyc_rd_o) exp_ic = m_rd % N;
      else               exp_ic = 0;
      if (int'(icyc_o) != exp_ic) m_icerr++;
      if (cyc_rd_o) m_rd++;
      if (done_o || trap_o) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("end_kind", done_o ? 1 : 2, e.kind);
          chk("latency", m_bcnt, e.lat);
          chk("stb_cycles", m_stb, e.stb);
          chk("we_cycles", m_we, e.we);
          chk("ldpar_count", m_lp, e.lp);
          chk("rd_cycles", m_rd, e.rd);
          chk("shft_cycles", m_sh, e.sh);
          chk("lsb_count", m_lsb, e.lsb);
          chk("msb_count", m_msb, e.msb);
          chk("icyc_errors", m_icerr, 0);
        end
        mon_clear();
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_op(input bit ld, input bit st, input bit sh, input bit mis,
                        input int d, input int s, input int gap);
    int   op, k_end, wbeg, wend, sbeg, send;
    exp_t e;
    step();
    start_i = 1'b1; instr_ld_i = ld; instr_st_i = st; shft_op_i = sh;
    misalngd_i  = 1'($urandom_range(0, 1));
    dmem_ack_i  = 1'($urandom_range(0, 1));
    shft_done_i = 1'($urandom_range(0, 1));
    op = ld ? 1 : st ? 2 : sh ? 3 : 0;
    wbeg = -1; wend = -1; sbeg = -1; send = -1; k_end = 0;
    e = '{default: 0};
    if (op != 0) begin
      if (op != 3 && mis) begin
        e = '{kind: 2, lat: N + 1, stb: 0, we: 0, lp: 0, rd: 0, sh: 0, lsb: 1, msb: 1};
      end else if (op == 2) begin
        e = '{kind: 1, lat: N + d + 2, stb: d + 1, we: d + 1, lp: 0, rd: 0, sh: 0,
              lsb: 1, msb: 1};
        wbeg = N + 1; wend = N + 1 + d;
      end else if (op == 1) begin
        e = '{kind: 1, lat: 2 * N + d + 2, stb: d + 1, we: 0, lp: 1, rd: N, sh: 0,
              lsb: 2, msb: 2};
        wbeg = N + 1; wend = N + 1 + d;
      end else begin
        e = '{kind: 1, lat: 2 * N + s + 2, stb: 0, we: 0, lp: 0, rd: N, sh: s + 1,
              lsb: 2, msb: 2};
        sbeg = N + 1; send = N + 1 + s;
      end
      k_end = e.lat;
      sb_q.push_back(e);
    end
    for (int k = 1; k <= k_end; k++) begin
      step();
      // stray starts and op bits while busy must be ignored
      start_i    = ($urandom_range(0, 3) == 0);
      instr_ld_i = 1'($urandom_range(0, 1));
      instr_st_i = 1'($urandom_range(0, 1));
      shft_op_i  = 1'($urandom_range(0, 1));
      misalngd_i = (k == N) ? mis : 1'($urandom_range(0, 1));
      if (k >= wbeg && k <= wend) dmem_ack_i = (k == wend);
      else                        dmem_ack_i = 1'($urandom_range(0, 1));
      if (k >= sbeg && k <= send) shft_done_i = (k == send);
      else                        shft_done_i = 1'($urandom_range(0, 1));
    end
    step();
    start_i = 1'b0;
    for (int g = 0; g < gap; g++) begin
      step();
      dmem_ack_i  = 1'($urandom_range(0, 1));
      shft_done_i = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic quiet();
    start_i = 1'b0; instr_ld_i = 1'b0; instr_st_i = 1'b0; shft_op_i = 1'b0;
    misalngd_i = 1'b0; shft_done_i = 1'b0; dmem_ack_i = 1'b0;
  endtask

  initial begin
    int exp8;
    quiet();
    s8_start = 1'b0; s8_ld = 1'b0; s8_ack = 1'b0;
    rst_in = 1'b0;
    #1;
    chk("reset_outputs", int'({dmem_stb_o, dmem_we_o, ld_par_o, icyc_o, icyc_lsb_o, icyc_msb_o,
                               cyc_rd_o, cyc_wt_o, cyc_shft_o, busy_o, done_o, trap_o}), 0);
    step();
    step();
    rst_in = 1'b1;
    step();

    // directed: load (ack 3rd WAIT cycle), store, shift, trapped load, ignored empty start
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 0);
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 0, 3, 1);
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      int bits;
      bits = int'($urandom_range(0, 7));
      run_op(bits[2], bits[1], bits[0], ($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
             int'($urandom_range(0, 2)));
    end
    quiet();
    repeat (4) step();
    chk("sb_drained", sb_q.size(), 0);

    // asynchronous reset during WAIT aborts the load; later ack is ignored
    step();
    start_i = 1'b1; instr_ld_i = 1'b1;
    for (int k = 1; k <= N + 1; k++) begin
      step();
      quiet();
    end
    chk("pre_reset_wait", int'({busy_o, dmem_stb_o}), 3);
    #2 rst_in = 1'b0;
    #1;
    chk("reset_abort", int'({dmem_stb_o, dmem_we_o, ld_par_o, icyc_o, icyc_lsb_o, icyc_msb_o,
                             cyc_rd_o, cyc_wt_o, cyc_shft_o, busy_o, done_o, trap_o}), 0);
    step();
    step();
    rst_in = 1'b1;
    dmem_ack_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("ack_after_reset", int'({busy_o, dmem_stb_o, ld_par_o, done_o}), 0);
    end
    quiet();

    // BWIDTH=8 load: ADR 1..4, WAIT 5 (ack), RD 6..9, DONE 10
    step();
    s8_start = 1'b1; s8_ld = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      // expected {icyc[1:0], lsb, msb, rd, wt, done, busy}
      if (k <= 4)       exp8 = ((k - 1) << 6) | ((k == 1) << 5) | ((k == 4) << 4) | 1;
      else if (k == 5)  exp8 = 6'b000100 | 1;
      else if (k <= 9)  exp8 = ((k - 6) << 6) | ((k == 6) << 5) | ((k == 9) << 4) | 8 | 1;
      else if (k == 10) exp8 = 2 | 1;
      else              exp8 = 0;
      chk("bw8_cycle", int'({s8_icyc, s8_lsb, s8_msb, s8_rd, s8_wt, s8_done, s8_busy}), exp8);
      s8_start = 1'b0; s8_ld = 1'b0;
      s8_ack = (k == 5);
    end
    chk("bw8_quiet", int'({s8_stb, s8_we, s8_ldpar, s8_shft, s8_trap}), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
